// File: rtl/pc_trace_pkg.sv
// Shared definitions for the post-retirement PC trace buffer: state encoding
// and default buffer depth.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        PT_IDLE    = 2'd0,
        PT_ARMED   = 2'd1,
        PT_CAPTURE = 2'd2,
        PT_FROZEN  = 2'd3
    } pt_state_e;

    localparam int PT_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x 32 storage for the trace buffer: one synchronous write port and one
// asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the level counter,
    // so clearing the array would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_trace_buf.sv
// Retired-PC trace buffer: rolling pre-trigger history, programmable
// post-trigger capture, then frozen for drain over a valid/ready port.
module pc_trace_buf
    import pc_trace_pkg::*;
#(
    parameter int DEPTH = PT_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          retire,
    input  logic [31:0]   pcM,
    input  logic          arm,
    input  logic [31:0]   trig_pc,
    input  logic [7:0]    post_cnt,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [AW:0]   level,
    output logic [1:0]    state,
    output logic          ovf
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    pt_state_e     st;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [7:0]    rem;
    logic [31:0]   ram_q;

    logic we;
    logic full;
    logic pop;

    // arm wins over a same-cycle retire, so the write is suppressed here
    assign we       = retire && !arm && (st == PT_ARMED || st == PT_CAPTURE);
    assign full     = (level == FULL);
    assign rd_valid = (st == PT_FROZEN) && (level != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? ram_q : '0;
    assign state    = st;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st    <= PT_IDLE;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
        end else if (arm) begin
            st    <= PT_ARMED;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (st)
                PT_ARMED: begin
                    if (retire && pcM == trig_pc) begin
                        rem <= post_cnt;
                        st  <= (post_cnt == 8'd0) ? PT_FROZEN : PT_CAPTURE;
                    end
                end
                PT_CAPTURE: begin
                    if (retire) begin
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            st <= PT_FROZEN;
                        end
                    end
                end
                default: ;
            endcase

            // Overwrite when full drags the read pointer along with the write
            if (we) begin
                wp <= wp + 1'b1;
                if (full) begin
                    rp <= rp + 1'b1;
                    if (st == PT_CAPTURE) begin
                        ovf <= 1'b1;
                    end
                end else begin
                    level <= level + 1'b1;
                end
            end else if (pop) begin
                rp    <= rp + 1'b1;
                level <= level - 1'b1;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wp),
        .wdata (pcM),
        .raddr (rp),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_pc_trace_buf.sv
// Directed bench for pc_trace_buf: a DEPTH=16 and a DEPTH=4 instance share
// stimulus; each scenario checks the instance it targets.
module tb_pc_trace_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire;
    logic [31:0] pcM;
    logic        arm;
    logic [31:0] trig_pc;
    logic [7:0]  post_cnt;
    logic        rd_ready;

    logic        rv16, rv4;
    logic [31:0] rd16, rd4;
    logic [4:0]  lv16;
    logic [2:0]  lv4;
    logic [1:0]  st16, st4;
    logic        ov16, ov4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_trace_buf #(.DEPTH(16)) u16 (
        .clk(clk), .reset(reset), .retire(retire), .pcM(pcM), .arm(arm),
        .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_ready(rd_ready),
        .rd_valid(rv16), .rd_data(rd16), .level(lv16), .state(st16), .ovf(ov16)
    );

    pc_trace_buf #(.DEPTH(4)) u4 (
        .clk(clk), .reset(reset), .retire(retire), .pcM(pcM), .arm(arm),
        .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_ready(rd_ready),
        .rd_valid(rv4), .rd_data(rd4), .level(lv4), .state(st4), .ovf(ov4)
    );

    typedef struct {
        logic        retire;
        logic [31:0] pc;
        logic        arm;
        logic        rdy;
        logic [1:0]  st;
        int          lvl;
        logic        rv;
        logic [31:0] data;
        logic        ovf;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string tag, input logic [1:0] s, input int l,
                         input logic v, input logic [31:0] d, input logic o);
        check({tag, " state16"}, 32'(st16), 32'(s));
        check({tag, " level16"}, 32'(lv16), 32'(l));
        check({tag, " rd_valid16"}, 32'(rv16), 32'(v));
        check({tag, " rd_data16"}, rd16, d);
        check({tag, " ovf16"}, 32'(ov16), 32'(o));
    endtask

    task automatic chk4(input string tag, input logic [1:0] s, input int l,
                        input logic v, input logic [31:0] d, input logic o);
        check({tag, " state4"}, 32'(st4), 32'(s));
        check({tag, " level4"}, 32'(lv4), 32'(l));
        check({tag, " rd_valid4"}, 32'(rv4), 32'(v));
        check({tag, " rd_data4"}, rd4, d);
        check({tag, " ovf4"}, 32'(ov4), 32'(o));
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 ns past the edge
    task automatic tick(input logic r, input logic [31:0] pc, input logic a, input logic rdy);
        retire   = r;
        pcM      = pc;
        arm      = a;
        rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        retire   = 1'b0;
        pcM      = '0;
        arm      = 1'b0;
        trig_pc  = '0;
        post_cnt = '0;
        rd_ready = 1'b0;
        #1;
        chk16("por", 2'd0, 0, 1'b0, 32'h0, 1'b0);
        chk4("por", 2'd0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // IDLE ignores retires
        tick(1'b1, 32'h40, 1'b0, 1'b1);
        chk16("idle", 2'd0, 0, 1'b0, 32'h0, 1'b0);

        // Basic window: trigger 0x40, two post-trigger entries, then drain
        trig_pc  = 32'h40;
        post_cnt = 8'd2;
        tbl[0]  = '{1'b0, 32'h00, 1'b1, 1'b0, 2'd1, 0, 1'b0, 32'h00, 1'b0};
        tbl[1]  = '{1'b1, 32'h30, 1'b0, 1'b0, 2'd1, 1, 1'b0, 32'h00, 1'b0};
        tbl[2]  = '{1'b1, 32'h34, 1'b0, 1'b0, 2'd1, 2, 1'b0, 32'h00, 1'b0};
        tbl[3]  = '{1'b1, 32'h38, 1'b0, 1'b0, 2'd1, 3, 1'b0, 32'h00, 1'b0};
        tbl[4]  = '{1'b1, 32'h3C, 1'b0, 1'b0, 2'd1, 4, 1'b0, 32'h00, 1'b0};
        tbl[5]  = '{1'b1, 32'h40, 1'b0, 1'b0, 2'd2, 5, 1'b0, 32'h00, 1'b0};
        tbl[6]  = '{1'b1, 32'h44, 1'b0, 1'b0, 2'd2, 6, 1'b0, 32'h00, 1'b0};
        tbl[7]  = '{1'b1, 32'h48, 1'b0, 1'b0, 2'd3, 7, 1'b1, 32'h30, 1'b0};
        tbl[8]  = '{1'b1, 32'h4C, 1'b0, 1'b0, 2'd3, 7, 1'b1, 32'h30, 1'b0};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 6, 1'b1, 32'h34, 1'b0};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 5, 1'b1, 32'h38, 1'b0};
        tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 4, 1'b1, 32'h3C, 1'b0};
        tbl[12] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 3, 1'b1, 32'h40, 1'b0};
        tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 2, 1'b1, 32'h44, 1'b0};
        tbl[14] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 1, 1'b1, 32'h48, 1'b0};
        tbl[15] = '{1'b0, 32'h00, 1'b0, 1'b1, 2'd3, 0, 1'b0, 32'h00, 1'b0};
        tbl[16] = '{1'b1, 32'h50, 1'b0, 1'b1, 2'd3, 0, 1'b0, 32'h00, 1'b0};
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].retire, tbl[i].pc, tbl[i].arm, tbl[i].rdy);
            chk16($sformatf("window[%0d]", i), tbl[i].st, tbl[i].lvl,
                  tbl[i].rv, tbl[i].data, tbl[i].ovf);
        end

        // History wrap on DEPTH=4: eight pre-trigger PCs, trigger with post_cnt=0
        trig_pc  = 32'h20;
        post_cnt = 8'd0;
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'(i * 4), 1'b0, 1'b0);
        end
        chk4("hist pre", 2'd1, 4, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h20, 1'b0, 1'b0);
        chk4("hist trig", 2'd3, 4, 1'b1, 32'h14, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hist drain[%0d]", i), rd4, 32'h14 + 32'(i * 4));
            tick(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk4("hist empty", 2'd3, 0, 1'b0, 32'h0, 1'b0);

        // Capture overflow on DEPTH=4: trigger 0x100, five post-trigger PCs
        trig_pc  = 32'h100;
        post_cnt = 8'd5;
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        end
        chk4("ovf mid", 2'd2, 4, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h114, 1'b0, 1'b0);
        chk4("ovf done", 2'd3, 4, 1'b1, 32'h108, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf drain[%0d]", i), rd4, 32'h108 + 32'(i * 4));
            tick(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk4("ovf empty", 2'd3, 0, 1'b0, 32'h0, 1'b1);

        // Arm collision while CAPTURE with ovf already set (DEPTH=4)
        trig_pc  = 32'h300;
        post_cnt = 8'd10;
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        end
        chk4("coll pre", 2'd2, 4, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h300, 1'b1, 1'b0);
        chk4("coll", 2'd1, 0, 1'b0, 32'h0, 1'b0);

        // Async reset mid-CAPTURE, no edge needed; resumes in IDLE
        tick(1'b1, 32'h300, 1'b0, 1'b0);
        chk4("rst pre", 2'd2, 1, 1'b0, 32'h0, 1'b0);
        do_reset();
        chk4("rst async", 2'd0, 0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h304, 1'b0, 1'b0);
        chk4("rst idle", 2'd0, 0, 1'b0, 32'h0, 1'b0);

        // Backpressure on DEPTH=16: three entries, hold five cycles, then drain
        trig_pc  = 32'h200;
        post_cnt = 8'd2;
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b1, 32'h200, 1'b0, 1'b0);
        tick(1'b1, 32'h204, 1'b0, 1'b0);
        tick(1'b1, 32'h208, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            chk16($sformatf("bp hold[%0d]", i), 2'd3, 3, 1'b1, 32'h200, 1'b0);
        end
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        chk16("bp pop0", 2'd3, 2, 1'b1, 32'h204, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        chk16("bp pop1", 2'd3, 1, 1'b1, 32'h208, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        chk16("bp pop2", 2'd3, 0, 1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_trace_buf.md
# pc_trace_buf

Post-retirement PC trace buffer that consumes the core's committed-PC output `pcM` and records a window of retired PCs around a trigger address for debug readout. It sits directly downstream of the single-cycle core top, next to instruction and data memory. Armed by a pulse, it keeps a rolling pre-trigger history, captures a programmable number of post-trigger PCs, then freezes for drain over a valid/ready read port.

## Interface
- `DEPTH`, 16, number of 32-bit entries; power of two, at least 4
- `AW`, $clog2(DEPTH), pointer width
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `retire`  in  1  `pcM` holds a retired instruction this cycle
- `pcM`  in  32  retired PC
- `arm`  in  1  single-cycle pulse: flush and start a new capture
- `trig_pc`  in  32  trigger address; sampled every cycle
- `post_cnt`  in  8  retirements to capture after the trigger entry; latched on trigger
- `rd_ready`  in  1  consumer accepts `rd_data`
- `rd_valid`  out  1  `rd_data` is valid
- `rd_data`  out  32  oldest buffered PC
- `level`  out  AW+1  entries held, 0..DEPTH
- `state`  out  2  IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3
- `ovf`  out  1  sticky: a CAPTURE-phase write overwrote an unread entry

## Operation
- Circular buffer with write pointer, read pointer and level counter.
- IDLE: no writes, no reads.
  - `arm` -> ARMED.
- `arm` in any state:
  - flush (pointers and level to 0), clear `ovf`, go to ARMED.
  - A `retire` in the same cycle is discarded.
- ARMED: each `retire` writes `pcM`.
  - If full, the oldest entry is overwritten; level stays DEPTH and `ovf` is not set (rolling history).
  - `retire && pcM==trig_pc`: the entry is written and the remaining count is loaded with `post_cnt`.
  - If `post_cnt==0`, go to FROZEN; otherwise go to CAPTURE.
- CAPTURE: each `retire` writes `pcM` and decrements the remaining count.
  - If full, the oldest entry is overwritten and `ovf` is set.
  - The write that takes the remaining count to 0 is stored, and the state goes to FROZEN.
  - `trig_pc` is ignored.
- FROZEN: `retire` is ignored.
  - `rd_valid = (level!=0)`.
  - A cycle with `rd_valid && rd_ready` pops one entry: read pointer +1 mod DEPTH, level -1.
  - The buffer stays FROZEN when empty; only `arm` or `reset` leaves FROZEN.
- `rd_valid` is 0 in every state other than FROZEN. While `rd_valid` is 0, `rd_data` is forced to 0.
- Pointers wrap modulo DEPTH. `level` saturates at DEPTH on overwrite; a write with overwrite advances both pointers.

## Timing
- Reset (async, immediate): `state`=IDLE, `level`=0, `rd_valid`=0, `rd_data`=0, `ovf`=0, pointers=0, remaining count=0. Buffer storage is not reset.
- Write latency: an entry written at edge N is reflected in `level` after edge N.
- The state transition on the trigger or final write happens at the same edge as that write.
- `rd_valid` rises in the cycle after entry to FROZEN, if `level>0`.
- `rd_data` is a combinational read of the entry at the read pointer. It is stable while `rd_valid && !rd_ready`.
- Pop takes effect at the edge; the next entry appears in the same cycle after that edge.
- Deassertion of `reset` mid-CAPTURE: the block resumes in IDLE. No partial state survives.

## Structure
- Shared package `pc_trace_pkg`:
  - 2-bit state encoding constants `PT_IDLE`, `PT_ARMED`, `PT_CAPTURE`, `PT_FROZEN`
  - default DEPTH
- Sub-module `trace_ram`:
  - DEPTH x 32 register array
  - one synchronous write port, one asynchronous read port
  - no reset
- The top level holds the FSM, pointers, level counter, remaining counter and `ovf`.

## Test plan
- Reset: assert `reset`=0 mid-run -> `state`=0, `level`=0, `rd_valid`=0, `rd_data`=0, `ovf`=0 with no clock edge required.
- Basic window (DEPTH=16):
  - Stimulus: `arm`, `trig_pc`=0x40, `post_cnt`=2; retire 0x30,0x34,0x38,0x3C,0x40,0x44,0x48,0x4C.
  - Response: FROZEN after 0x48; `level`=7; drain yields 0x30..0x48 in order; 0x4C absent; `ovf`=0.
- History wrap (DEPTH=4):
  - Stimulus: retire 0x00..0x1C in steps of 4 while ARMED, then 0x20 = `trig_pc` with `post_cnt`=0.
  - Response: FROZEN immediately; drain yields 0x14,0x18,0x1C,0x20; `ovf`=0.
- Capture overflow (DEPTH=4):
  - Stimulus: `trig_pc`=0x100, `post_cnt`=5; retire 0x100..0x114.
  - Response: FROZEN; drain yields 0x108,0x10C,0x110,0x114; `ovf`=1.
- Arm collision:
  - Stimulus: `arm` and `retire` with `pcM`=`trig_pc` in the same cycle, while CAPTURE.
  - Response: `state`=ARMED, `level`=0, `ovf`=0.
- Backpressure:
  - Stimulus: FROZEN with 3 entries; hold `rd_ready`=0 for 5 cycles, then 1.
  - Response: `rd_data` holds the first entry for 5 cycles; then 3 pops on consecutive cycles; `rd_valid`=0 when `level`=0.
